// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- configurable UART receiver (start / data / optional parity /
// 1-2 stop bits) with glitch rejection on the start bit and frame-error
// lockout until the line returns high.
//
// Build option:
//   UART_RX_MAJORITY_EN  defined   -> each bit decision is the 2-of-3 majority
//                                     of the line at the mid point and its two
//                                     neighbours, decided one cycle after mid.
//                        undefined -> single sample at the mid point, no vote
//                                     registers.
//
// Parameters:
//   DATA_BITS     data bits per frame (5..9)
//   CLKS_PER_BIT  clock cycles per bit (>=3, >=5 with majority voting)
//   PARITY        0 none, 1 even, 2 odd
//   STOP_BITS     stop bits checked per frame (1 or 2)
//
// Ports:
//   i_Clock       sole clock, rising edge
//   i_Reset       asynchronous active-high reset
//   i_Rx_Serial   asynchronous serial input, idle high
//   o_Rx_DV       one-cycle frame-complete strobe
//   o_Rx_Data     received word, LSB = first data bit (held between strobes)
//   o_Parity_Err  parity mismatch on the last frame (held between strobes)
//   o_Frame_Err   a stop bit sampled low on the last frame (held)
//   o_Busy        high whenever the receiver is not idle
module uart_rx_cfg #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 5,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW  = $clog2(DATA_BITS) + 1;
  localparam int MID = (CLKS_PER_BIT - 1) / 2;

  // The IDLE cycle that first sees the line low is line offset 0, so START's
  // counter value c corresponds to line offset c+1 within the start bit.
`ifdef UART_RX_MAJORITY_EN
  localparam int START_PT = MID;       // decide at offset MID+1
`else
  localparam int START_PT = MID - 1;   // decide at offset MID
`endif

  localparam logic [CW-1:0] START_CNT = CW'(START_PT);
  localparam logic [CW-1:0] BIT_CNT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_CLEANUP   = 3'd5;
  localparam logic [2:0] S_WAIT_HIGH = 3'd6;

  logic                 sync_1;
  logic                 line;
  logic                 samp;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] data_buf;
  logic                 pend_par;
  logic                 pend_frame;

  // Two-flop synchronizer; idle level is high so both flops reset to 1.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync_1 <= 1'b1;
      line   <= 1'b1;
    end else begin
      sync_1 <= i_Rx_Serial;
      line   <= sync_1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // vote[0] = line one cycle ago, vote[1] = line two cycles ago; at a
  // decision point these are offsets MID and MID-1 while line is MID+1.
  logic [1:0] vote;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      vote <= '0;
    end else begin
      vote <= {vote[0], line};
    end
  end

  assign samp = (vote[1] & vote[0]) | (vote[1] & line) | (vote[0] & line);
`else
  assign samp = line;
`endif

  assign o_Busy = (state != S_IDLE);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      data_buf     <= '0;
      pend_par     <= 1'b0;
      pend_frame   <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Data    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt        <= '0;
          idx        <= '0;
          pend_par   <= 1'b0;
          pend_frame <= 1'b0;
          if (!line) begin
            state <= S_START;
          end
        end

        S_START: begin
          if (cnt == START_CNT) begin
            cnt <= '0;
            // A high sample means the low pulse was a glitch: drop it silently.
            state <= samp ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (cnt == BIT_CNT) begin
            cnt <= '0;
            // LSB-first shift: after DATA_BITS samples bit 0 sits in [0].
            data_buf <= {samp, data_buf[DATA_BITS-1:1]};
            if (idx == LAST_DATA) begin
              idx   <= '0;
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_PARITY: begin
          if (cnt == BIT_CNT) begin
            cnt <= '0;
            if (PARITY == 2) begin
              pend_par <= ~(^data_buf ^ samp);
            end else begin
              pend_par <= ^data_buf ^ samp;
            end
            state <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (cnt == BIT_CNT) begin
            cnt <= '0;
            if (!samp) begin
              pend_frame <= 1'b1;
            end
            if (idx == LAST_STOP) begin
              // Results are registered on entry so they are visible during
              // the single CLEANUP cycle together with the strobe.
              idx          <= '0;
              state        <= S_CLEANUP;
              o_Rx_DV      <= 1'b1;
              o_Rx_Data    <= data_buf;
              o_Parity_Err <= (PARITY != 0) && pend_par;
              o_Frame_Err  <= pend_frame | ~samp;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_CLEANUP: begin
          o_Rx_DV <= 1'b0;
          // A low stop bit may be a break; wait for the line to go high so a
          // held-low line cannot be mistaken for new start bits.
          state   <= pend_frame ? S_WAIT_HIGH : S_IDLE;
        end

        S_WAIT_HIGH: begin
          if (line) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg -- self-checking bench for uart_rx_cfg. Four receivers with
// different configurations are driven from independent serial lines; every
// strobe is compared with a queue of expected frames computed from the
// transmitted bits.
module tb_uart_rx_cfg;

  // Instance configurations (must match the parameter overrides below).
  localparam int unsigned CFG_CPB  [4] = '{5, 5, 7, 6};
  localparam int unsigned CFG_BITS [4] = '{8, 8, 8, 7};
  localparam int unsigned CFG_PAR  [4] = '{0, 1, 0, 2};
  localparam int unsigned CFG_STOP [4] = '{1, 1, 1, 2};

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] rx;

  logic       dv0, perr0, ferr0, busy0;
  logic [7:0] data0;
  logic       dv1, perr1, ferr1, busy1;
  logic [7:0] data1;
  logic       dv2, perr2, ferr2, busy2;
  logic [7:0] data2;
  logic       dv3, perr3, ferr3, busy3;
  logic [6:0] data3;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  logic [3:0] prev_dv;
  int         tests;
  int         fails;

  uart_rx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(5), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv0),
    .o_Rx_Data(data0), .o_Parity_Err(perr0), .o_Frame_Err(ferr0), .o_Busy(busy0));

  uart_rx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(5), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv1),
    .o_Rx_Data(data1), .o_Parity_Err(perr1), .o_Frame_Err(ferr1), .o_Busy(busy1));

  uart_rx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(7), .PARITY(0), .STOP_BITS(1)) u_dut2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv2),
    .o_Rx_Data(data2), .o_Parity_Err(perr2), .o_Frame_Err(ferr2), .o_Busy(busy2));

  uart_rx_cfg #(.DATA_BITS(7), .CLKS_PER_BIT(6), .PARITY(2), .STOP_BITS(2)) u_dut3 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[3]), .o_Rx_DV(dv3),
    .o_Rx_Data(data3), .o_Parity_Err(perr3), .o_Frame_Err(ferr3), .o_Busy(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic get_busy(input int unsigned w);
    case (w)
      0: return busy0;
      1: return busy1;
      2: return busy2;
      default: return busy3;
    endcase
  endfunction

  function automatic int unsigned q_size(input int unsigned w);
    case (w)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic push_exp(input int unsigned w, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    case (w)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  // Parity error from the transmitted ones count.
  function automatic logic model_perr(input int unsigned mode, input logic [8:0] d, input logic pb);
    int unsigned ones;
    if (mode == 0) return 1'b0;
    ones = $countones(d) + 32'(pb);
    if (mode == 1) return (ones % 2) != 0;
    return (ones % 2) == 0;
  endfunction

  task automatic compare_strobe(input int unsigned w, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    check("dv_not_back_to_back", 32'(prev_dv[w]), 32'd0);
    if (q_size(w) == 0) begin
      check("unexpected_dv", 32'd1, 32'd0);
    end else begin
      case (w)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        default: e = q3.pop_front();
      endcase
      check($sformatf("data_u%0d", w), 32'(d), 32'(e.data));
      check($sformatf("perr_u%0d", w), 32'(pe), 32'(e.perr));
      check($sformatf("ferr_u%0d", w), 32'(fe), 32'(e.ferr));
    end
  endtask

  // Strobe monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (dv0) compare_strobe(0, {1'b0, data0}, perr0, ferr0);
    if (dv1) compare_strobe(1, {1'b0, data1}, perr1, ferr1);
    if (dv2) compare_strobe(2, {1'b0, data2}, perr2, ferr2);
    if (dv3) compare_strobe(3, {2'b0, data3}, perr3, ferr3);
    prev_dv = {dv3, dv2, dv1, dv0};
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int unsigned w, input logic v, input int unsigned n);
    rx[w] = v;
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame on line w and queues the frame the receiver must report.
  task automatic send_frame(input int unsigned w, input logic [8:0] data, input logic pb,
                            input logic [1:0] stops, input int unsigned tail_low);
    int unsigned cpb;
    int unsigned nb;
    logic [8:0]  d;
    logic        fe;
    cpb = CFG_CPB[w];
    nb  = CFG_BITS[w];
    d   = data;
    for (int i = 0; i < 9; i++) if (i >= int'(nb)) d[i] = 1'b0;
    fe = 1'b0;
    for (int s = 0; s < int'(CFG_STOP[w]); s++) if (!stops[s]) fe = 1'b1;
    push_exp(w, d, model_perr(CFG_PAR[w], d, pb), fe);
    drive_bit(w, 1'b0, cpb);
    for (int i = 0; i < int'(nb); i++) begin
      rx[w] = d[i];
      if (i == 2) begin
        repeat (cpb / 2) @(negedge clk);
        check("busy_mid_frame", 32'(get_busy(w)), 32'd1);
        repeat (cpb - cpb / 2) @(negedge clk);
      end else begin
        repeat (cpb) @(negedge clk);
      end
    end
    if (CFG_PAR[w] != 0) drive_bit(w, pb, cpb);
    for (int s = 0; s < int'(CFG_STOP[w]); s++) drive_bit(w, stops[s], cpb);
    if (tail_low > 0) begin
      rx[w] = 1'b0;
      repeat (tail_low) @(negedge clk);
      check("busy_line_held_low", 32'(get_busy(w)), 32'd1);
    end
    rx[w] = 1'b1;
  endtask

  initial begin
    logic [8:0]  rd;
    logic [1:0]  rs;
    int unsigned w;
    tests   = 0;
    fails   = 0;
    prev_dv = '0;
    rst     = 1'b1;
    rx      = '1;
    idle(3);
    check("reset_dv", 32'(dv0), 32'd0);
    check("reset_data", 32'(data0), 32'd0);
    check("reset_errs", 32'({perr0, ferr0}), 32'd0);
    check("reset_busy", 32'({busy0, busy1, busy2, busy3}), 32'd0);
    rst = 1'b0;
    idle(5);

    // 8N1 0xA5.
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 0);
    idle(10);
    check("a5_strobe_count", 32'(q_size(0)), 32'd0);
    check("a5_busy_after", 32'(busy0), 32'd0);

    // Even parity: 0x03 with parity 1 is wrong, with parity 0 is right.
    send_frame(1, 9'h003, 1'b1, 2'b11, 0);
    idle(10);
    check("par1_perr_held", 32'(perr1), 32'd1);
    send_frame(1, 9'h003, 1'b0, 2'b11, 0);
    idle(10);
    check("par0_perr_held", 32'(perr1), 32'd0);
    check("par_strobe_count", 32'(q_size(1)), 32'd0);

    // Bad stop bit, line held low three bit times, then a clean frame.
    send_frame(0, 9'h055, 1'b0, 2'b10, 15);
    idle(10);
    check("ferr_held", 32'(ferr0), 32'd1);
    send_frame(0, 9'h03C, 1'b0, 2'b11, 0);
    idle(10);
    check("ferr_strobe_count", 32'(q_size(0)), 32'd0);

    // Two-cycle low glitch: rejected, outputs unchanged.
    drive_bit(0, 1'b0, 2);
    drive_bit(0, 1'b1, 20);
    check("glitch_busy", 32'(busy0), 32'd0);
    check("glitch_data_held", 32'(data0), 32'h3C);
    check("glitch_errs_held", 32'({perr0, ferr0}), 32'd0);

    // Reset during data bit 4 of 0xFF.
    drive_bit(0, 1'b0, 5);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 5);
    rx[0] = 1'b1;
    idle(2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_data", 32'(data0), 32'd0);
    check("async_rst_flags", 32'({dv0, perr0, ferr0, busy0}), 32'd0);
    idle(3);
    rst = 1'b0;
    idle(10);
    check("post_rst_busy", 32'(busy0), 32'd0);
    send_frame(0, 9'h03C, 1'b0, 2'b11, 0);
    idle(10);
    check("post_rst_strobe_count", 32'(q_size(0)), 32'd0);

    // CLKS_PER_BIT=7: one-cycle low spike at the mid point (offset 3) of bit 0.
`ifdef UART_RX_MAJORITY_EN
    push_exp(2, 9'h001, 1'b0, 1'b0);
`else
    push_exp(2, 9'h000, 1'b0, 1'b0);
`endif
    drive_bit(2, 1'b0, 7);
    drive_bit(2, 1'b1, 3);
    drive_bit(2, 1'b0, 1);
    drive_bit(2, 1'b1, 3);
    for (int i = 1; i < 8; i++) drive_bit(2, 1'b0, 7);
    drive_bit(2, 1'b1, 7);
    idle(14);
    check("spike_strobe_count", 32'(q_size(2)), 32'd0);

    // Randomized frames across all configurations.
    for (int n = 0; n < 40; n++) begin
      w  = $urandom_range(0, 3);
      rd = 9'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send_frame(w, rd, 1'($urandom_range(0, 1)), rs, 0);
      idle($urandom_range(CFG_CPB[w], 3 * CFG_CPB[w]));
    end

    idle(30);
    for (int i = 0; i < 4; i++) check($sformatf("missing_dv_u%0d", i), 32'(q_size(i)), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 5, i_Clock cycles per bit (legal >=3; >=5 when UART_RX_MAJORITY_EN is defined).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame (legal 1 or 2).
REQ-005 SHALL have port i_Clock, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port i_Reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port i_Rx_Serial, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port o_Rx_DV, output, 1, one-cycle frame-complete strobe.
REQ-009 SHALL have port o_Rx_Data, output, DATA_BITS, received word, LSB = first data bit.
REQ-010 SHALL have port o_Parity_Err, output, 1, parity mismatch on last frame.
REQ-011 SHALL have port o_Frame_Err, output, 1, a stop bit sampled low on last frame.
REQ-012 SHALL have port o_Busy, output, 1, high whenever FSM is not IDLE.

Function
REQ-013 SHALL pass i_Rx_Serial through a 2-flop synchronizer (both flops reset to 1); all decisions use the second flop (line).
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH.
REQ-015 IDLE: counter and bit index held 0; line==0 -> START.
REQ-016 START: count to MID=(CLKS_PER_BIT-1)/2; sample there; sample 0 -> clear counter, go DATA; sample 1 -> IDLE, no strobe, no flag change (glitch rejection).
REQ-017 DATA: sample every CLKS_PER_BIT cycles after the previous sample; store into o_Rx_Data[index], index 0..DATA_BITS-1; after last bit -> PARITY if PARITY!=0, else STOP.
REQ-018 PARITY: one sample; parity error = (XOR of data bits XOR sampled bit) != 0 for even, == 0 for odd.
REQ-019 STOP: STOP_BITS samples, each CLKS_PER_BIT apart; any 0 sample sets the pending frame error.
REQ-020 CLEANUP: exactly one cycle; o_Rx_DV=1; o_Parity_Err/o_Frame_Err updated in this same cycle; then IDLE if no frame error, else WAIT_HIGH.
REQ-021 WAIT_HIGH: stay until line==1, then IDLE; a line held low after a bad stop bit SHALL NOT produce further frames.
REQ-022 o_Rx_Data, o_Parity_Err, o_Frame_Err SHALL hold their values between strobes; a glitch-rejected start leaves them unchanged.
REQ-023 o_Parity_Err SHALL be constant 0 when PARITY=0.
REQ-024 Frame with errors SHALL still deliver data and strobe o_Rx_DV.
REQ-025 o_Rx_DV SHALL be asserted for at most one cycle per frame and never in consecutive cycles.
REQ-026 Counter width SHALL be $clog2(CLKS_PER_BIT)+1; bit index width $clog2(DATA_BITS)+1; no wrap within legal parameters.

Reset
REQ-027 On i_Reset=1, immediately and regardless of state: FSM IDLE, counters 0, synchronizer flops 1, vote registers 0, all outputs 0.
REQ-028 Reset mid-frame SHALL discard the partial frame with no strobe; reception resumes with the first start bit after reset release.

Configuration
REQ-029 Macro UART_RX_MAJORITY_EN defined: each sample (start, data, parity, stop) SHALL be the 2-of-3 majority of line at counts MID-1, MID, MID+1, and the decision is taken at MID+1; all later sample points shift uniformly by one cycle.
REQ-030 Macro undefined: each sample SHALL be the single line value at count MID; no vote logic is synthesised.

Verification
REQ-031 CLKS_PER_BIT=5, 8N1, send 0xA5 -> exactly one o_Rx_DV, o_Rx_Data=0xA5, both errors 0, o_Busy 0 afterwards.
REQ-032 PARITY=1, send 0x03 with parity bit 1 -> o_Rx_Data=0x03, o_Parity_Err=1; resend with parity bit 0 -> o_Parity_Err=0.
REQ-033 Send 0x55 with stop bit 0, then hold line low 3 bit times, then high, then 0x3C -> first strobe 0x55 with o_Frame_Err=1, no strobe while line low, second strobe 0x3C with o_Frame_Err=0.
REQ-034 Line low for 2 cycles only (CLKS_PER_BIT=5) -> no o_Rx_DV; o_Busy returns 0; outputs unchanged.
REQ-035 Assert i_Reset during data bit 4 of 0xFF -> all outputs 0 asynchronously, no strobe; next frame 0x3C received correctly.
REQ-036 CLKS_PER_BIT=7, send 0x01 with a 1-cycle low spike at the mid-sample point of bit 0 -> with UART_RX_MAJORITY_EN o_Rx_Data=0x01; without it o_Rx_Data=0x00.
